// File: rtl/descr_pkg.sv
// Shared constants, types and the single-bit LFSR step for descrambler_par.
// Latency: n/a (package). Backpressure: n/a.
// Contents: LFSR/lock widths, default seed, tap positions and mask, FSM state type.
package descr_pkg;

  localparam int LFSR_W    = 24;
  localparam int LOCK_BITS = 24;
  localparam int CNT_W     = 5;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 24'h1F_EEDD;
  localparam logic [CNT_W-1:0]  LOCK_CNT     = CNT_W'(LOCK_BITS);

  // Tap positions of x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1, counted
  // in the shift register where s[0] holds the most recently received bit.
  localparam int TAP_0 = 23;
  localparam int TAP_1 = 21;
  localparam int TAP_2 = 16;
  localparam int TAP_3 = 8;
  localparam int TAP_4 = 5;
  localparam int TAP_5 = 2;
  localparam logic [LFSR_W-1:0] TAP_MASK =
    (24'd1 << TAP_0) | (24'd1 << TAP_1) | (24'd1 << TAP_2) |
    (24'd1 << TAP_3) | (24'd1 << TAP_4) | (24'd1 << TAP_5);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // One serial step: returns {out_bit, s_next}. The register is fed with the
  // received (scrambled) bit, which is what makes the scheme self-synchronising.
  function automatic logic [LFSR_W:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                input logic              in_bit);
    logic out_bit;
    out_bit = in_bit ^ (^(s & TAP_MASK));
    return {out_bit, s[LFSR_W-2:0], in_bit};
  endfunction

endpackage

// File: rtl/descrambler_par_if.sv
// Stream bundle for descrambler_par: scrambled words in, descrambled words out.
// Latency: n/a (interface). Backpressure: valid/ready on both sides.
// Signals: in_data/in_valid/in_ready (upstream), out_data/out_valid/out_ready (downstream).
interface descrambler_par_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // master: the environment (source of scrambled words, sink of results)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // slave: the descrambler
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/descr_unroll.sv
// Combinational DATA_W-step unrolling of the self-synchronising descrambler LFSR.
// Latency: 0 cycles (pure logic). Backpressure: none, caller decides when to commit s_next_o.
// Ports: data_i (bit 0 earliest), s_i current LFSR; data_o descrambled, s_next_o advanced LFSR.
module descr_unroll
  import descr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [LFSR_W-1:0] s_i,
  output logic [DATA_W-1:0] data_o,
  output logic [LFSR_W-1:0] s_next_o
);

  logic [LFSR_W-1:0] s_var;
  logic [LFSR_W:0]   step;

  always_comb begin
    s_var  = s_i;
    step   = '0;
    data_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      step      = lfsr_step(s_var, data_i[i]);
      data_o[i] = step[LFSR_W];
      s_var     = step[LFSR_W-1:0];
    end
    s_next_o = s_var;
  end

endmodule

// File: rtl/descrambler_par.sv
// Parallel self-synchronising descrambler (x^23+x^21+x^16+x^8+x^5+x^2+1), DATA_W bits/beat.
// Latency: 1 cycle from accepted input beat to out_valid; full throughput of one beat per clock.
// Backpressure: in_ready = enable && (!out_valid || out_ready); output register holds while stalled.
// Ports: clk, rst (sync, active-high), enable (low flushes/reseeds), descr_rst (reseed request),
//        bus (descrambler_par_if.slave stream), locked (>= 24 bits absorbed since last reseed).
// Optional macro DESCR_BYPASS_EN adds input 'bypass': pass data through, freeze LFSR and counter.
module descrambler_par
  import descr_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic descr_rst,
`ifdef DESCR_BYPASS_EN
  input  logic bypass,
`endif
  descrambler_par_if.slave bus,
  output logic locked
);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              in_ready;
  logic              accept;
  logic              byp;
  logic [LFSR_W-1:0] s_base;
  logic [CNT_W-1:0]  cnt_base;
  logic [LFSR_W-1:0] s_unr;
  logic [DATA_W-1:0] unr_data;
  logic [7:0]        cnt_sum;

`ifdef DESCR_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  assign in_ready = enable && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // A restart takes effect before the beat accepted in the same cycle, so the
  // unroller always starts from the post-restart state.
  assign s_base   = descr_rst ? SEED : s_q;
  assign cnt_base = descr_rst ? '0   : cnt_q;

  descr_unroll #(
    .DATA_W (DATA_W)
  ) u_unroll (
    .data_i   (bus.in_data),
    .s_i      (s_base),
    .data_o   (unr_data),
    .s_next_o (s_unr)
  );

  // Bit counter saturates at LOCK_BITS; the wider sum keeps DATA_W up to 64 safe.
  assign cnt_sum = {3'b000, cnt_base} + 8'(DATA_W);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (!enable) begin
      // Disable wins over restart and drops any pending output word.
      state_d     = IDLE;
      s_d         = SEED;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      s_d   = s_base;
      cnt_d = cnt_base;
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        out_valid_d = 1'b1;
        if (byp) begin
          out_data_d = bus.in_data;
        end else begin
          out_data_d = unr_data;
          s_d        = s_unr;
          cnt_d      = (cnt_sum >= 8'(LOCK_BITS)) ? LOCK_CNT : cnt_sum[CNT_W-1:0];
        end
      end
      // IDLE with enable high behaves as TRAIN for the first beat.
      state_d = (cnt_d == LOCK_CNT) ? LOCKED : TRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= SEED;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign locked        = (state_q == LOCKED);

endmodule

// File: tb/tb_descrambler_par.sv
// Self-checking bench for descrambler_par (DATA_W = 8) against a serial history model.
// Latency: checks 1-cycle beat latency. Backpressure: random and directed out_ready stalls.
module tb_descrambler_par;

  localparam int          DW      = 8;
  localparam logic [23:0] SEED_TB = 24'h1F_EEDD;

  logic clk;
  logic rst;
  logic enable;
  logic descr_rst;
  logic locked;
  logic bypass;

  descrambler_par_if #(.DATA_W(DW)) bus ();

  descrambler_par #(
    .DATA_W (DW),
    .SEED   (SEED_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .descr_rst (descr_rst),
`ifdef DESCR_BYPASS_EN
    .bypass    (bypass),
`endif
    .bus       (bus.master),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: received-bit history, oldest first. The 24 seed bits
  // stand in for bits "received" before the reseed. Output bit n is
  // in[n] ^ x[n-3] ^ x[n-6] ^ x[n-9] ^ x[n-17] ^ x[n-22] ^ x[n-24].
  bit          hist[$];
  int          nbits;
  logic        exp_ovalid;
  logic [7:0]  exp_word;
  logic        exp_locked;
  logic [7:0]  got_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reseed();
    hist.delete();
    for (int j = 23; j >= 0; j--) hist.push_back(SEED_TB[j]);
    nbits = 0;
  endtask

  task automatic model_word(input logic [7:0] d, output logic [7:0] o);
    int L;
    o = '0;
    for (int i = 0; i < DW; i++) begin
      L = hist.size();
      o[i] = d[i] ^ hist[L-3] ^ hist[L-6] ^ hist[L-9] ^ hist[L-17] ^ hist[L-22] ^ hist[L-24];
      hist.push_back(d[i]);
      if (hist.size() > 40) void'(hist.pop_front());
    end
    nbits = (nbits + DW >= 24) ? 24 : nbits + DW;
  endtask

  // One clock: check outputs settled from the previous edge, drive inputs,
  // update the model with whatever handshakes the model says happen.
  task automatic cycle(input logic vld, input logic [7:0] dat, input logic ordy,
                       input logic drst, input logic en);
    logic rdy_exp;
    logic [7:0] w;
    @(negedge clk);
    chk("locked", 64'(locked), 64'(exp_locked));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ovalid));
    if (exp_ovalid) chk("out_data", 64'(bus.out_data), 64'(exp_word));
    bus.in_valid  = vld;
    bus.in_data   = dat;
    bus.out_ready = ordy;
    descr_rst     = drst;
    enable        = en;
    #1;
    rdy_exp = en && (!exp_ovalid || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy_exp));
    if (!en) begin
      exp_ovalid = 1'b0;
      reseed();
    end else begin
      if (exp_ovalid && ordy) begin
        got_q.push_back(bus.out_data);
        exp_ovalid = 1'b0;
      end
      if (drst) reseed();
      if (vld && rdy_exp) begin
        model_word(dat, w);
        exp_word   = w;
        exp_ovalid = 1'b1;
      end
    end
    exp_locked = en && (nbits >= 24);
    @(posedge clk);
  endtask

  // Self-synchronising scrambler, state holds transmitted bits.
  logic [23:0] sc;
  task automatic scramble(input logic [7:0] p, output logic [7:0] c);
    c = '0;
    for (int i = 0; i < DW; i++) begin
      c[i] = p[i] ^ sc[23] ^ sc[21] ^ sc[16] ^ sc[8] ^ sc[5] ^ sc[2];
      sc   = {sc[22:0], c[i]};
    end
  endtask

  logic [7:0]  pt[12];
  logic [7:0]  ct;
  logic [63:0] diff, mask;
  int          offs[7];

  initial begin
    rst = 1'b1; enable = 1'b0; descr_rst = 1'b0; bypass = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst_locked",    64'(locked),        64'(0));
    rst = 1'b0;
    reseed();
    exp_ovalid = 1'b0; exp_word = '0; exp_locked = 1'b0;

    // Seed check: zero input from SEED gives B4; lock after the third beat.
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    #1 chk("lock_beat1", 64'(locked), 64'(0));
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    #1 chk("lock_beat2", 64'(locked), 64'(0));
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    #1 chk("lock_beat3", 64'(locked), 64'(1));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("seed_b4", 64'(got_q[0]), 64'(8'hB4));

    // Self-sync: scrambler seeded differently; after 24 bits output == plaintext.
    got_q.delete();
    sc = 24'h000001;
    for (int k = 0; k < 12; k++) begin
      pt[k] = 8'($urandom);
      scramble(pt[k], ct);
      cycle(1'b1, ct, 1'b1, 1'b0, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("selfsync_count", 64'(got_q.size()), 64'(12));
    for (int k = 3; k < 12; k++) chk("selfsync", 64'(got_q[k]), 64'(pt[k]));

    // Error multiplication: flip serial bit 20 of the next 64-bit segment.
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      pt[k] = 8'($urandom);
      scramble(pt[k], ct);
      if (k == 2) ct[4] = ~ct[4];
      cycle(1'b1, ct, 1'b1, 1'b0, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    diff = '0;
    for (int k = 0; k < 8; k++) diff[k*8 +: 8] = got_q[k] ^ pt[k];
    offs = '{0, 3, 6, 9, 17, 22, 24};
    mask = '0;
    for (int j = 0; j < 7; j++) mask[20 + offs[j]] = 1'b1;
    chk("err_count", 64'($countones(diff)), 64'(7));
    chk("err_mask", diff, mask);

    // Backpressure: five stalled cycles with in_valid high, then resume.
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // Restart with a beat while locked: beat from SEED, lock drops, relocks at 24 bits.
    got_q.delete();
    cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    #1 chk("drst_unlock", 64'(locked), 64'(0));
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    chk("drst_b4", 64'(got_q[$]), 64'(8'hB4));
    #1 chk("drst_lock_16", 64'(locked), 64'(0));
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    #1 chk("drst_relock", 64'(locked), 64'(1));

    // Disable while a word is stalled, then re-enable from SEED.
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 chk("dis_out_valid", 64'(bus.out_valid), 64'(0));
    chk("dis_locked", 64'(locked), 64'(0));
    got_q.delete();
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("reen_b4", 64'(got_q[$]), 64'(8'hB4));

    // Randomised traffic with stalls, restarts and occasional disables.
    for (int c = 0; c < 600; c++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0, ($urandom % 60) != 0);
      if (got_q.size() > 16) got_q.delete();
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
